smi_config_seq: RTL and testbench

//  Table-driven MDIO/SMI PHY configuration sequencer, one command per table entry.

---
 rtl/smi_config_seq.sv | 244 ++++++++++++++++++++++++
 tb/tb_smi_config_seq.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smi_config_seq.sv
// Table-driven MDIO/SMI PHY configuration sequencer.
// After a power-up delay it walks cmd_table entry by entry (WRITE, READ,
// VERIFY, POLL) and drives an external SMI engine through req/done.
//
// Engine handshake: smi_write_req / smi_read_req is a single-cycle pulse with
// smi_reg_addr / smi_write_data already stable. The engine then owns the bus
// until it pulses smi_done (with smi_data_valid on reads). No new request is
// raised before that done is seen, so a request never hits a busy engine.
module smi_config_seq #(
  parameter int         REF_CLK       = 50,
  parameter int         INIT_DELAY_US = 60000,
  parameter int         NUM_CMDS      = 4,
  parameter logic [4:0] PHY_ADDR      = 5'd1,
  parameter int         SMI_TIMEOUT   = 65535,
  parameter int         POLL_GAP      = 1000,
  parameter int         POLL_MAX      = 100
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NUM_CMDS*39-1:0] cmd_table,
  output logic                   smi_rst_n,
  output logic [4:0]             smi_phy_addr,
  output logic [4:0]             smi_reg_addr,
  output logic                   smi_write_req,
  output logic [15:0]            smi_write_data,
  output logic                   smi_read_req,
  input  logic [15:0]            smi_read_data,
  input  logic                   smi_data_valid,
  input  logic                   smi_done,
  output logic                   busy,
  output logic                   cfg_done,
  output logic                   error,
  output logic [4:0]             err_index,
  output logic [1:0]             err_code,
  output logic [15:0]            last_rd_data,
  output logic [2:0]             dbg_state
);

  localparam int DELAY_CYC = REF_CLK * INIT_DELAY_US;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_READ   = 2'b01;
  localparam logic [1:0] OP_VERIFY = 2'b10;
  localparam logic [1:0] OP_POLL   = 2'b11;

  localparam logic [1:0] CODE_TIMEOUT = 2'b01;
  localparam logic [1:0] CODE_VERIFY  = 2'b10;
  localparam logic [1:0] CODE_POLL    = 2'b11;

  typedef enum logic [2:0] {
    S_PWR_WAIT = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT     = 3'd2,
    S_CHECK    = 3'd3,
    S_GAP      = 3'd4,
    S_NEXT     = 3'd5,
    S_DONE     = 3'd6,
    S_FAIL     = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_next;

  // One shared cycle counter: power-up delay, transaction timeout, poll gap.
  // It restarts from zero on every state change.
  logic [31:0] r_cnt;
  logic [31:0] r_att;
  logic [4:0]  r_idx;

  logic        r_smi_rst_n;
  logic [4:0]  r_phy_addr;
  logic [4:0]  r_reg_addr;
  logic        r_write_req;
  logic [15:0] r_write_data;
  logic        r_read_req;
  logic        r_busy;
  logic        r_cfg_done;
  logic        r_error;
  logic [4:0]  r_err_index;
  logic [1:0]  r_err_code;
  logic [15:0] r_last_rd;

  logic [38:0] w_entry;
  logic [1:0]  w_op;
  logic [4:0]  w_reg;
  logic [15:0] w_mask;
  logic [15:0] w_data;
  logic        w_match;
  logic [1:0]  w_fail_code;

  assign w_entry = cmd_table[39*int'(r_idx) +: 39];
  assign w_op    = w_entry[38:37];
  assign w_reg   = w_entry[36:32];
  assign w_mask  = w_entry[31:16];
  assign w_data  = w_entry[15:0];
  // Compare against the latest captured read; a done without data_valid
  // therefore reuses the previous value.
  assign w_match = ((r_last_rd & w_mask) == (w_data & w_mask));

  // State register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_PWR_WAIT;
    else        r_state <= w_next;
  end

  // Next-state decode and the error code that goes with a transition to FAIL
  always_comb begin
    w_next      = r_state;
    w_fail_code = 2'b00;
    case (r_state)
      S_PWR_WAIT: if (r_cnt == 32'(DELAY_CYC - 1)) w_next = S_ISSUE;
      S_ISSUE:    w_next = S_WAIT;
      S_WAIT: begin
        if (smi_done) begin
          w_next = S_CHECK;
        end else if (r_cnt == 32'(SMI_TIMEOUT - 1)) begin
          w_next      = S_FAIL;
          w_fail_code = CODE_TIMEOUT;
        end
      end
      S_CHECK: begin
        case (w_op)
          OP_VERIFY: begin
            if (w_match) begin
              w_next = S_NEXT;
            end else begin
              w_next      = S_FAIL;
              w_fail_code = CODE_VERIFY;
            end
          end
          OP_POLL: begin
            if (w_match) begin
              w_next = S_NEXT;
            end else if (r_att < 32'(POLL_MAX)) begin
              w_next = S_GAP;
            end else begin
              w_next      = S_FAIL;
              w_fail_code = CODE_POLL;
            end
          end
          default: w_next = S_NEXT;
        endcase
      end
      S_GAP:  if (r_cnt == 32'(POLL_GAP - 1)) w_next = S_ISSUE;
      S_NEXT: w_next = (r_idx == 5'(NUM_CMDS - 1)) ? S_DONE : S_ISSUE;
      S_DONE: if (start) w_next = S_ISSUE;
      S_FAIL: if (start) w_next = S_ISSUE;
      default: w_next = S_PWR_WAIT;
    endcase
  end

  // Datapath: counters, entry index, SMI request outputs and status flags
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_att        <= '0;
      r_idx        <= '0;
      r_smi_rst_n  <= 1'b0;
      r_phy_addr   <= '0;
      r_reg_addr   <= '0;
      r_write_req  <= 1'b0;
      r_write_data <= '0;
      r_read_req   <= 1'b0;
      r_busy       <= 1'b0;
      r_cfg_done   <= 1'b0;
      r_error      <= 1'b0;
      r_err_index  <= '0;
      r_err_code   <= '0;
      r_last_rd    <= '0;
    end else begin
      r_write_req <= 1'b0;
      r_read_req  <= 1'b0;
      r_cnt       <= (w_next != r_state) ? 32'd0 : r_cnt + 32'd1;

      case (r_state)
        S_PWR_WAIT: begin
          r_busy <= 1'b1;
          if (w_next == S_ISSUE) begin
            r_smi_rst_n <= 1'b1;
            r_phy_addr  <= PHY_ADDR;
            r_idx       <= '0;
            r_att       <= 32'd1;
          end
        end
        S_ISSUE: begin
          r_reg_addr <= w_reg;
          if (w_op == OP_WRITE) begin
            r_write_data <= w_data;
            r_write_req  <= 1'b1;
          end else begin
            r_read_req   <= 1'b1;
          end
        end
        S_WAIT: if (smi_data_valid) r_last_rd <= smi_read_data;
        S_GAP:  if (w_next == S_ISSUE) r_att <= r_att + 32'd1;
        S_NEXT: begin
          if (w_next == S_ISSUE) begin
            r_idx <= r_idx + 5'd1;
            r_att <= 32'd1;
          end
        end
        S_DONE, S_FAIL: begin
          if (start) begin
            r_cfg_done  <= 1'b0;
            r_error     <= 1'b0;
            r_err_code  <= '0;
            r_err_index <= '0;
            r_idx       <= '0;
            r_att       <= 32'd1;
            r_busy      <= 1'b1;
          end
        end
        default: ;
      endcase

      if (w_next == S_FAIL && r_state != S_FAIL) begin
        r_error     <= 1'b1;
        r_err_code  <= w_fail_code;
        r_err_index <= r_idx;
        r_busy      <= 1'b0;
      end
      if (w_next == S_DONE && r_state != S_DONE) begin
        r_cfg_done <= 1'b1;
        r_busy     <= 1'b0;
      end
    end
  end

  assign smi_rst_n      = r_smi_rst_n;
  assign smi_phy_addr   = r_phy_addr;
  assign smi_reg_addr   = r_reg_addr;
  assign smi_write_req  = r_write_req;
  assign smi_write_data = r_write_data;
  assign smi_read_req   = r_read_req;
  assign busy           = r_busy;
  assign cfg_done       = r_cfg_done;
  assign error          = r_error;
  assign err_index      = r_err_index;
  assign err_code       = r_err_code;
  assign last_rd_data   = r_last_rd;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_smi_config_seq.sv
// Testbench for smi_config_seq: SMI engine BFM plus a table-walking
// reference model that predicts the transaction log and final status.
module tb_smi_config_seq;

  localparam int         REF_CLK       = 1;
  localparam int         INIT_DELAY_US = 20;
  localparam int         NUM_CMDS      = 4;
  localparam logic [4:0] PHY_ADDR      = 5'd1;
  localparam int         SMI_TIMEOUT   = 50;
  localparam int         POLL_GAP      = 4;
  localparam int         POLL_MAX      = 3;
  localparam int         DELAY_CYC     = REF_CLK * INIT_DELAY_US;
  // done seen -> CHECK cycle, POLL_GAP idle cycles, ISSUE cycle, then req
  localparam int         POLL_SPACING  = POLL_GAP + 3;

  logic                   sys_clk = 1'b0;
  logic                   rst_n   = 1'b0;
  logic                   start   = 1'b0;
  logic [NUM_CMDS*39-1:0] cmd_table = '0;
  logic                   smi_rst_n;
  logic [4:0]             smi_phy_addr;
  logic [4:0]             smi_reg_addr;
  logic                   smi_write_req;
  logic [15:0]            smi_write_data;
  logic                   smi_read_req;
  logic [15:0]            smi_read_data;
  logic                   smi_data_valid;
  logic                   smi_done;
  logic                   busy;
  logic                   cfg_done;
  logic                   error;
  logic [4:0]             err_index;
  logic [1:0]             err_code;
  logic [15:0]            last_rd_data;
  logic [2:0]             dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [38:0] tbl [NUM_CMDS];
  logic [21:0] exp_q[$];          // {is_read, reg, value}
  logic [21:0] act_q[$];
  logic [15:0] rd_q[$];           // values the BFM returns, in order
  logic [15:0] dir_q[$];          // directed read values fed to the model
  int          req_cyc[$];
  int          done_cyc[$];
  bit          bfm_hang = 1'b0;

  logic        m_done, m_err;
  logic [1:0]  m_code;
  logic [4:0]  m_idx;
  logic [15:0] m_last = '0;

  smi_config_seq #(
    .REF_CLK(REF_CLK), .INIT_DELAY_US(INIT_DELAY_US), .NUM_CMDS(NUM_CMDS),
    .PHY_ADDR(PHY_ADDR), .SMI_TIMEOUT(SMI_TIMEOUT), .POLL_GAP(POLL_GAP),
    .POLL_MAX(POLL_MAX)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .cmd_table(cmd_table),
    .smi_rst_n(smi_rst_n), .smi_phy_addr(smi_phy_addr),
    .smi_reg_addr(smi_reg_addr), .smi_write_req(smi_write_req),
    .smi_write_data(smi_write_data), .smi_read_req(smi_read_req),
    .smi_read_data(smi_read_data), .smi_data_valid(smi_data_valid),
    .smi_done(smi_done), .busy(busy), .cfg_done(cfg_done), .error(error),
    .err_index(err_index), .err_code(err_code), .last_rd_data(last_rd_data),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic logic [38:0] ent(input logic [1:0] op, input logic [4:0] rg,
                                      input logic [15:0] mk, input logic [15:0] dt);
    return {op, rg, mk, dt};
  endfunction

  // SMI engine BFM: logs each request, answers after 0..2 cycles unless hung
  initial begin : bfm
    logic [15:0] v;
    bit          is_rd;
    int          lat;
    smi_done = 1'b0; smi_data_valid = 1'b0; smi_read_data = '0;
    forever begin
      @(posedge sys_clk); #1;
      if (rst_n && (smi_write_req || smi_read_req)) begin
        is_rd = smi_read_req;
        req_cyc.push_back(cyc);
        if (is_rd) begin
          v = (rd_q.size() > 0) ? rd_q.pop_front() : 16'h0000;
          act_q.push_back({1'b1, smi_reg_addr, v});
        end else begin
          act_q.push_back({1'b0, smi_reg_addr, smi_write_data});
        end
        if (!bfm_hang) begin
          lat = $urandom_range(0, 2);
          repeat (lat) begin @(posedge sys_clk); #1; end
          smi_read_data  = is_rd ? v : 16'($urandom);
          smi_data_valid = is_rd;
          smi_done       = 1'b1;
          done_cyc.push_back(cyc);
          @(posedge sys_clk); #1;
          smi_done = 1'b0; smi_data_valid = 1'b0;
        end
      end
    end
  end

  // Reference model: walk the table, consume read values, predict the log
  task automatic model_run(input bit gen);
    logic [1:0]  op;
    logic [4:0]  rg;
    logic [15:0] mk, dt, v;
    bit          ok;
    int          tries;
    exp_q.delete(); rd_q.delete();
    m_err = 1'b0; m_code = 2'b00; m_idx = '0;
    for (int i = 0; i < NUM_CMDS && !m_err; i++) begin
      {op, rg, mk, dt} = tbl[i];
      if (op == 2'b00) begin
        exp_q.push_back({1'b0, rg, dt});
      end else begin
        ok = 1'b0;
        tries = (op == 2'b11) ? POLL_MAX : 1;
        for (int a = 0; a < tries && !ok; a++) begin
          if (gen) v = ($urandom_range(0, 2) != 0) ? ((16'($urandom) & ~mk) | (dt & mk)) : 16'($urandom);
          else     v = dir_q.pop_front();
          rd_q.push_back(v);
          exp_q.push_back({1'b1, rg, v});
          m_last = v;
          ok = (op == 2'b01) || ((v & mk) == (dt & mk));
        end
        if (!ok) begin
          m_err  = 1'b1;
          m_code = (op == 2'b10) ? 2'b10 : 2'b11;
          m_idx  = 5'(i);
        end
      end
    end
    m_done = !m_err;
  endtask

  task automatic load_table();
    for (int i = 0; i < NUM_CMDS; i++) cmd_table[39*i +: 39] = tbl[i];
  endtask

  task automatic random_writes();
    for (int i = 0; i < NUM_CMDS; i++) tbl[i] = ent(2'b00, 5'($urandom), 16'h0, 16'($urandom));
  endtask

  // Load table, pulse start, wait (bounded) for cfg_done or error
  task automatic launch(output bit to, output int fin);
    load_table();
    @(posedge sys_clk); #1;
    act_q.delete(); req_cyc.delete(); done_cyc.delete();
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    to = 1'b1; fin = 0;
    for (int k = 0; k < 2000; k++) begin
      if (cfg_done || error) begin to = 1'b0; fin = cyc; break; end
      @(posedge sys_clk); #1;
    end
    repeat (10) @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    int first_rst, first_req;
    random_writes();
    dir_q.delete();
    model_run(1'b0);
    load_table();
    rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if ({smi_rst_n, smi_phy_addr, smi_reg_addr, smi_write_req, smi_write_data, smi_read_req, busy,
         cfg_done, error, err_index, err_code, last_rd_data} !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero outputs required all 0 (rst_n=%b smi_rst_n=%b busy=%b)", rst_n, smi_rst_n, busy);
    end
    act_q.delete();
    rst_n = 1'b1;
    first_rst = -1; first_req = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge sys_clk); #1;
      if (smi_rst_n && first_rst < 0) first_rst = k;
      if ((smi_write_req || smi_read_req) && first_req < 0) first_req = k;
    end
    checks++; if (first_rst != DELAY_CYC) begin errors++; $display("FAIL reset_smi_rst_rise cycle %0d required %0d", first_rst, DELAY_CYC); end
    checks++; if (first_req != DELAY_CYC + 1) begin errors++; $display("FAIL reset_first_req cycle %0d required %0d", first_req, DELAY_CYC + 1); end
    for (int k = 0; k < 300 && !cfg_done && !error; k++) begin @(posedge sys_clk); #1; end
    repeat (5) @(posedge sys_clk);
    #1;
    checks++; if ({cfg_done, error, busy} !== 3'b100) begin errors++; $display("FAIL reset_run_status done/err/busy=%b%b%b required 100", cfg_done, error, busy); end
    checks++; if (smi_phy_addr !== PHY_ADDR) begin errors++; $display("FAIL reset_phy_addr got %h required %h", smi_phy_addr, PHY_ADDR); end
    checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL reset_log_len got %0d required %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++; if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin errors++; $display("FAIL reset_log[%0d] got %h required %h", i, (i < act_q.size()) ? act_q[i] : 22'h0, exp_q[i]); end
    end
  endtask

  task automatic test_write_verify();
    bit to; int fin;
    tbl[0] = ent(2'b00, 5'd17, 16'h0000, 16'h5555);
    tbl[1] = ent(2'b10, 5'd17, 16'hFFFF, 16'h5555);
    tbl[2] = ent(2'b01, 5'd2,  16'h0000, 16'h0000);
    tbl[3] = ent(2'b00, 5'd9,  16'h0000, 16'h0A0B);
    dir_q = '{16'h5555, 16'h1234};
    model_run(1'b0);
    launch(to, fin);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL wv_finish timed_out=%0b required 0", to); end
    checks++; if ({cfg_done, error} !== {m_done, m_err}) begin errors++; $display("FAIL wv_status done/err=%b%b required %b%b", cfg_done, error, m_done, m_err); end
    checks++; if (last_rd_data !== m_last) begin errors++; $display("FAIL wv_last_rd got %h required %h", last_rd_data, m_last); end
    checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL wv_log_len got %0d required %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++; if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin errors++; $display("FAIL wv_log[%0d] got %h required %h", i, (i < act_q.size()) ? act_q[i] : 22'h0, exp_q[i]); end
    end
  endtask

  task automatic test_verify_fail();
    bit to; int fin;
    random_writes();
    tbl[0] = ent(2'b10, 5'd1, 16'h0004, 16'h0004);
    dir_q = '{16'h7949};
    model_run(1'b0);
    launch(to, fin);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL vf_finish timed_out=%0b required 0", to); end
    checks++; if ({cfg_done, error, busy} !== {m_done, m_err, 1'b0}) begin errors++; $display("FAIL vf_status done/err/busy=%b%b%b required %b%b0", cfg_done, error, busy, m_done, m_err); end
    checks++; if ({err_code, err_index} !== {m_code, m_idx}) begin errors++; $display("FAIL vf_code_idx got %b/%0d required %b/%0d", err_code, err_index, m_code, m_idx); end
    checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL vf_log_len got %0d required %0d", act_q.size(), exp_q.size()); end
  endtask

  task automatic test_poll();
    bit to; int fin; int g1, g2;
    random_writes();
    tbl[0] = ent(2'b11, 5'd17, 16'hC000, 16'h8000);
    dir_q = '{16'h0000, 16'h0000, 16'h8C00};
    model_run(1'b0);
    fork
      launch(to, fin);
      begin
        // start while the poll is still running must be ignored
        repeat (12) @(posedge sys_clk);
        #2; start = 1'b1;
        @(posedge sys_clk); #2; start = 1'b0;
      end
    join
    g1 = (req_cyc.size() > 1 && done_cyc.size() > 0) ? req_cyc[1] - done_cyc[0] : -1;
    g2 = (req_cyc.size() > 2 && done_cyc.size() > 1) ? req_cyc[2] - done_cyc[1] : -1;
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL poll_finish timed_out=%0b required 0", to); end
    checks++; if ({cfg_done, error} !== {m_done, m_err}) begin errors++; $display("FAIL poll_status done/err=%b%b required %b%b", cfg_done, error, m_done, m_err); end
    checks++; if (g1 != POLL_SPACING || g2 != POLL_SPACING) begin errors++; $display("FAIL poll_spacing got %0d,%0d required %0d", g1, g2, POLL_SPACING); end
    checks++; if (last_rd_data !== m_last) begin errors++; $display("FAIL poll_last_rd got %h required %h", last_rd_data, m_last); end
    checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL poll_log_len got %0d required %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++; if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin errors++; $display("FAIL poll_log[%0d] got %h required %h", i, (i < act_q.size()) ? act_q[i] : 22'h0, exp_q[i]); end
    end
    // exhausted poll
    tbl[0] = ent(2'b11, 5'd5, 16'h00FF, 16'h00A5);
    dir_q = '{16'h1200, 16'h34A4, 16'hFF00};
    model_run(1'b0);
    launch(to, fin);
    checks++; if ({to, cfg_done, error} !== {1'b0, m_done, m_err}) begin errors++; $display("FAIL pollx_status to/done/err=%b%b%b required 0%b%b", to, cfg_done, error, m_done, m_err); end
    checks++; if ({err_code, err_index} !== {m_code, m_idx}) begin errors++; $display("FAIL pollx_code_idx got %b/%0d required %b/%0d", err_code, err_index, m_code, m_idx); end
    checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL pollx_reads got %0d required %0d", act_q.size(), exp_q.size()); end
    checks++; if (last_rd_data !== m_last) begin errors++; $display("FAIL pollx_last_rd got %h required %h", last_rd_data, m_last); end
  endtask

  task automatic test_timeout();
    bit to; int fin; int lat;
    random_writes();
    dir_q.delete();
    model_run(1'b0);
    bfm_hang = 1'b1;
    launch(to, fin);
    bfm_hang = 1'b0;
    lat = (req_cyc.size() > 0) ? fin - req_cyc[0] : -1;
    checks++; if ({to, error, cfg_done} !== 3'b010) begin errors++; $display("FAIL to_status to/err/done=%b%b%b required 010", to, error, cfg_done); end
    checks++; if ({err_code, err_index} !== {2'b01, 5'd0}) begin errors++; $display("FAIL to_code_idx got %b/%0d required 01/0", err_code, err_index); end
    checks++; if (lat != SMI_TIMEOUT) begin errors++; $display("FAIL to_latency got %0d required %0d", lat, SMI_TIMEOUT); end
    checks++; if (req_cyc.size() != 1) begin errors++; $display("FAIL to_traffic got %0d requests required 1", req_cyc.size()); end
    // re-run the same table from entry 0 with a responsive engine
    model_run(1'b0);
    launch(to, fin);
    checks++; if ({to, cfg_done, error, err_code} !== {1'b0, m_done, m_err, m_code}) begin errors++; $display("FAIL to_rerun_status to/done/err/code=%b%b%b%b required 0%b%b%b", to, cfg_done, error, err_code, m_done, m_err, m_code); end
    checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL to_rerun_log_len got %0d required %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++; if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin errors++; $display("FAIL to_rerun_log[%0d] got %h required %h", i, (i < act_q.size()) ? act_q[i] : 22'h0, exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit to; int fin;
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < NUM_CMDS; i++) tbl[i] = ent(2'($urandom), 5'($urandom), 16'($urandom), 16'($urandom));
      model_run(1'b1);
      launch(to, fin);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL rnd%0d_finish timed_out=%0b required 0", n, to); end
      checks++; if ({cfg_done, error, busy} !== {m_done, m_err, 1'b0}) begin errors++; $display("FAIL rnd%0d_status done/err/busy=%b%b%b required %b%b0", n, cfg_done, error, busy, m_done, m_err); end
      checks++; if ({err_code, err_index} !== {m_code, m_idx}) begin errors++; $display("FAIL rnd%0d_code_idx got %b/%0d required %b/%0d", n, err_code, err_index, m_code, m_idx); end
      checks++; if (last_rd_data !== m_last) begin errors++; $display("FAIL rnd%0d_last_rd got %h required %h", n, last_rd_data, m_last); end
      checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_log_len got %0d required %0d", n, act_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        checks++; if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_log[%0d] got %h required %h", n, i, (i < act_q.size()) ? act_q[i] : 22'h0, exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen; int first_rst, first_req;
    random_writes();
    dir_q.delete();
    model_run(1'b0);
    load_table();
    bfm_hang = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (smi_write_req) begin seen = 1'b1; break; end
      @(posedge sys_clk); #1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rm_req_seen got %0b required 1", seen); end
    repeat (3) @(posedge sys_clk);
    #1;
    rst_n = 1'b0;
    #1;
    m_last = '0;
    checks++;
    if ({smi_rst_n, smi_phy_addr, smi_reg_addr, smi_write_req, smi_write_data, smi_read_req, busy,
         cfg_done, error, err_index, err_code, last_rd_data} !== '0) begin
      errors++; $display("FAIL rm_reset_outputs got nonzero outputs required all 0 (smi_rst_n=%b busy=%b reg=%h)", smi_rst_n, busy, smi_reg_addr);
    end
    @(posedge sys_clk); #1;
    bfm_hang = 1'b0;
    act_q.delete();
    rst_n = 1'b1;
    first_rst = -1; first_req = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge sys_clk); #1;
      if (smi_rst_n && first_rst < 0) first_rst = k;
      if ((smi_write_req || smi_read_req) && first_req < 0) first_req = k;
    end
    checks++; if (first_rst != DELAY_CYC) begin errors++; $display("FAIL rm_smi_rst_rise cycle %0d required %0d", first_rst, DELAY_CYC); end
    checks++; if (first_req != DELAY_CYC + 1) begin errors++; $display("FAIL rm_first_req cycle %0d required %0d", first_req, DELAY_CYC + 1); end
    for (int k = 0; k < 300 && !cfg_done && !error; k++) begin @(posedge sys_clk); #1; end
    repeat (5) @(posedge sys_clk);
    #1;
    checks++; if ({cfg_done, error, last_rd_data} !== {m_done, m_err, m_last}) begin errors++; $display("FAIL rm_status done/err/last=%b%b%h required %b%b%h", cfg_done, error, last_rd_data, m_done, m_err, m_last); end
    checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL rm_log_len got %0d required %0d", act_q.size(), exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_write_verify();
    test_verify_fail();
    test_poll();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
